// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Constants shared by the UART transmitter and receiver: frame geometry,
// start/stop bit levels and the transmitter state encoding.
// Also provides a helper that assembles a complete 8N1 frame from a byte.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int UART_DATA_BITS  = 8;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;

    // Transmitter state encoding
    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_SEND = 1'b1;

    // Frame layout, bit 0 first on the line: start, data LSB..MSB, stop.
    function automatic logic [UART_FRAME_BITS-1:0] uart_build_frame(
        input logic [UART_DATA_BITS-1:0] data
    );
        return {UART_STOP_BIT, data, UART_START_BIT};
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// ---------------------------------------------------------------------------
// uart_baud_counter
// Bit-period timer. Counts clock cycles from 0 to SYMBOL_EDGE_TIME-1 and
// wraps; symbol_edge is high during the cycle in which the count is at its
// last value, i.e. the final cycle of each bit period.
//
// Ports
//   clk          system clock
//   rst          synchronous active-high reset, count -> 0
//   clear        hold / restart the count at 0
//   symbol_edge  1-cycle pulse on the last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_counter #(
    parameter int SYMBOL_EDGE_TIME = 10,
    parameter int COUNT_WIDTH      = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic symbol_edge
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(SYMBOL_EDGE_TIME - 1);

    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] count_next;

    // Decoded from the register only, so the pulse has no input path.
    assign symbol_edge = (count_reg == LAST_COUNT);

    always_comb begin
        count_next = count_reg + COUNT_WIDTH'(1);
        if (symbol_edge) begin
            count_next = '0;
        end
        if (clear) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// ---------------------------------------------------------------------------
// uart_transmitter
// 8N1 serial transmit engine. Accepts one byte per ready/valid handshake and
// shifts it out as start bit, eight data bits LSB first, stop bit, each bit
// lasting CLOCK_FREQ/BAUD_RATE clock cycles.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset (abandons any frame)
//   data_in        byte to send, sampled only on handshake
//   data_in_valid  producer has a byte
//   data_in_ready  transmitter is idle and can accept a byte
//   serial_out     UART line, idle high
// ---------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
    localparam int COUNTER_WIDTH       = (CLOCK_COUNTER_WIDTH > 0) ? CLOCK_COUNTER_WIDTH : 1;

    localparam logic [3:0] LAST_BIT_INDEX = 4'(UART_FRAME_BITS - 1);

    logic [0:0]                 state_reg;
    logic [0:0]                 state_next;
    logic [UART_FRAME_BITS-1:0] shift_reg;
    logic [UART_FRAME_BITS-1:0] shift_next;
    logic [UART_FRAME_BITS-1:0] shift_right;
    logic [3:0]                 bit_index_reg;
    logic [3:0]                 bit_index_next;

    logic symbol_edge;
    logic handshake;
    logic counter_clear;

    // Outputs decode registered state only.
    assign data_in_ready = (state_reg == STATE_IDLE);
    assign serial_out    = (state_reg == STATE_SEND) ? shift_reg[0] : UART_STOP_BIT;

    assign handshake = data_in_valid && data_in_ready;

    // Counter sits at 0 while idle, so the first SEND cycle starts a fresh
    // bit period without needing a separate restart on handshake.
    assign counter_clear = (state_reg == STATE_IDLE);

    uart_baud_counter #(
        .SYMBOL_EDGE_TIME (SYMBOL_EDGE_TIME),
        .COUNT_WIDTH      (COUNTER_WIDTH)
    ) u_baud_counter (
        .clk         (clk),
        .rst         (rst),
        .clear       (counter_clear),
        .symbol_edge (symbol_edge)
    );

    // Right shift by one; the vacated MSB fills with the idle/stop level.
    genvar gi;
    generate
        for (gi = 0; gi < UART_FRAME_BITS - 1; gi++) begin : g_shift
            assign shift_right[gi] = shift_reg[gi+1];
        end
    endgenerate
    assign shift_right[UART_FRAME_BITS-1] = UART_STOP_BIT;

    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_index_next = bit_index_reg;
        case (state_reg)
            STATE_IDLE: begin
                bit_index_next = '0;
                if (handshake) begin
                    shift_next = uart_build_frame(data_in);
                    state_next = STATE_SEND;
                end
            end
            STATE_SEND: begin
                if (symbol_edge) begin
                    shift_next = shift_right;
                    if (bit_index_reg == LAST_BIT_INDEX) begin
                        // Stop bit has run its full period.
                        bit_index_next = '0;
                        state_next     = STATE_IDLE;
                    end else begin
                        bit_index_next = bit_index_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next     = STATE_IDLE;
                bit_index_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= STATE_IDLE;
            bit_index_reg <= '0;
            shift_reg     <= '1;
        end else begin
            state_reg     <= state_next;
            bit_index_reg <= bit_index_next;
            shift_reg     <= shift_next;
        end
    end

endmodule
